// File: rtl/convolve_pkg.sv
// Shared types, default widths and the output scaling helper for the convolution engine.
package convolve_pkg;

  localparam int DW_DEF    = 16;
  localparam int FRAC_DEF  = 15;
  localparam int ACC_W_DEF = 40;

  // Working width of the scaling helper; accumulators up to 63 bits fit.
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  // Arithmetic right shift by frac (truncation), then clamp to a signed dw-bit range.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             frac,
    input int unsigned             dw
  );
    logic signed [SAT_W-1:0] sh;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sh = v >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (sh > hi) begin
      return hi;
    end else if (sh < lo) begin
      return lo;
    end
    return sh;
  endfunction

endpackage

// File: rtl/convolve_mac.sv
// Time-shared signed multiply-accumulate with synchronous clear and a scaled "final" tap.
module conv_mac
  import convolve_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] final_val
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;

  assign prod = a * b;
  assign sum  = acc + ACC_W'(prod);

  // Value that would be written back if this product is the last term of the output.
  assign final_val = DW'(sat_shift(SAT_W'(sum), FRAC, DW));

  // Accumulator: clear has priority so a write-back cycle starts the next output from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/convolve.sv
// Batch full linear convolution engine using one MAC per clock, output-major ordering.
module convolve
  import convolve_pkg::*;
#(
  parameter int FILT_LEN = 20,
  parameter int SIG_LEN  = 121,
  parameter int DW       = DW_DEF,
  parameter int FRAC     = FRAC_DEF,
  parameter int ACC_W    = ACC_W_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load,
  input  logic [FILT_LEN*DW-1:0]                flat_filter_coeff,
  input  logic [SIG_LEN*DW-1:0]                 flat_signal,
  output logic [(FILT_LEN+SIG_LEN-1)*DW-1:0]    flat_conv_result,
  output logic                                  is_completed
);

  localparam int OUT_LEN = FILT_LEN + SIG_LEN - 1;
  localparam int KW      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int XW      = (SIG_LEN > 1) ? $clog2(SIG_LEN) : 1;
  localparam int NW      = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

  state_t                state;
  logic [NW-1:0]         n;
  logic [KW-1:0]         k;
  logic signed [DW-1:0]  h_reg [FILT_LEN];
  logic signed [DW-1:0]  x_reg [SIG_LEN];
  logic [DW-1:0]         y_reg [OUT_LEN];

  int unsigned           n_i;
  int unsigned           kmax_i;
  int unsigned           kmin_nxt_i;
  logic                  last_k;
  logic                  last_n;
  logic [XW-1:0]         x_idx;
  logic [KW-1:0]         k_nxt;
  logic                  step;
  logic                  mac_clear;
  logic                  mac_en;
  logic signed [DW-1:0]  mac_final;

  // Index bookkeeping: k range for the current output and the start k of the next one.
  always_comb begin
    n_i        = 32'(n);
    kmax_i     = (n_i < FILT_LEN - 1) ? n_i : FILT_LEN - 1;
    kmin_nxt_i = (n_i + 1 >= SIG_LEN) ? n_i + 2 - SIG_LEN : 0;
    last_k     = (32'(k) == kmax_i);
    last_n     = (n_i == OUT_LEN - 1);
    x_idx      = XW'(n_i - 32'(k));
    k_nxt      = KW'(kmin_nxt_i);
  end

  // The LOAD->RUN edge already does MAC #1, so LOAD with load low is a regular step.
  assign step      = ((state == LOAD) || (state == RUN)) && !load;
  assign mac_en    = step;
  assign mac_clear = load || (step && last_k);

  conv_mac #(
    .DW    (DW),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .clear     (mac_clear),
    .en        (mac_en),
    .a         (h_reg[k]),
    .b         (x_reg[x_idx]),
    .final_val (mac_final)
  );

  // Control FSM with input capture, index stepping and result write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      is_completed <= 1'b0;
      n            <= '0;
      k            <= '0;
      for (int unsigned i = 0; i < FILT_LEN; i++) h_reg[i] <= '0;
      for (int unsigned i = 0; i < SIG_LEN; i++)  x_reg[i] <= '0;
      for (int unsigned i = 0; i < OUT_LEN; i++)  y_reg[i] <= '0;
    end else if (load) begin
      state        <= LOAD;
      is_completed <= 1'b0;
      n            <= '0;
      k            <= '0;
      for (int unsigned i = 0; i < FILT_LEN; i++) h_reg[i] <= flat_filter_coeff[i*DW +: DW];
      for (int unsigned i = 0; i < SIG_LEN; i++)  x_reg[i] <= flat_signal[i*DW +: DW];
      for (int unsigned i = 0; i < OUT_LEN; i++)  y_reg[i] <= '0;
    end else begin
      case (state)
        LOAD, RUN: begin
          if (last_k) begin
            y_reg[n] <= mac_final;
            if (last_n) begin
              state        <= DONE;
              is_completed <= 1'b1;
            end else begin
              state <= RUN;
              n     <= n + 1'b1;
              k     <= k_nxt;
            end
          end else begin
            state <= RUN;
            k     <= k + 1'b1;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  for (genvar g = 0; g < OUT_LEN; g++) begin : g_out
    assign flat_conv_result[g*DW +: DW] = y_reg[g];
  end

endmodule

// File: tb/tb_convolve.sv
// Randomised and directed bench for convolve against a direct-sum convolution model.
module tb_convolve;

  localparam int FL   = 20;
  localparam int SL   = 121;
  localparam int OL   = FL + SL - 1;
  localparam int DW   = 16;
  localparam int MACS = FL * SL;

  logic               clk = 1'b0;
  logic               rst;
  logic               load;
  logic [FL*DW-1:0]   fh;
  logic [SL*DW-1:0]   fx;
  logic [OL*DW-1:0]   res;
  logic               done;

  int                 vectors = 0;
  int                 miscompares = 0;
  int                 h_m [FL];
  int                 x_m [SL];
  logic [DW-1:0]      y_m [OL];
  int                 edges;

  always #5 clk = ~clk;

  convolve #(
    .FILT_LEN (FL),
    .SIG_LEN  (SL),
    .DW       (DW),
    .FRAC     (15),
    .ACC_W    (40)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .load              (load),
    .flat_filter_coeff (fh),
    .flat_signal       (fx),
    .flat_conv_result  (res),
    .is_completed      (done)
  );

  task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  // Drive the flat inputs from the model arrays and compute the expected outputs.
  task automatic build_model();
    longint acc;
    for (int i = 0; i < FL; i++) fh[i*DW +: DW] = h_m[i][DW-1:0];
    for (int i = 0; i < SL; i++) fx[i*DW +: DW] = x_m[i][DW-1:0];
    for (int n = 0; n < OL; n++) begin
      acc = 0;
      for (int j = 0; j < FL; j++) begin
        if ((n - j >= 0) && (n - j < SL)) acc += longint'(h_m[j]) * longint'(x_m[n - j]);
      end
      acc = acc >>> 15;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      y_m[n] = acc[DW-1:0];
    end
  endtask

  task automatic fill_random(input int span);
    for (int i = 0; i < FL; i++) h_m[i] = int'($urandom_range(0, 2*span - 1)) - span;
    for (int i = 0; i < SL; i++) x_m[i] = int'($urandom_range(0, 2*span - 1)) - span;
  endtask

  task automatic fill_const(input int hv, input int xv);
    for (int i = 0; i < FL; i++) h_m[i] = hv;
    for (int i = 0; i < SL; i++) x_m[i] = xv;
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < FL; i++) fh[i*DW +: DW] = DW'($urandom);
    for (int i = 0; i < SL; i++) fx[i*DW +: DW] = DW'($urandom);
  endtask

  // One load pulse; the next rising edge is the first one with load sampled low.
  task automatic start_run();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (cnt < 3000) begin
      @(posedge clk);
      cnt++;
      #1;
      if (done === 1'b1) break;
    end
  endtask

  function automatic logic [DW-1:0] y_at(input int n);
    return res[n*DW +: DW];
  endfunction

  task automatic check_results(input string tag);
    for (int n = 0; n < OL; n++) check(tag, n, 32'(y_at(n)), 32'(y_m[n]));
  endtask

  task automatic run_once(input string tag, input bit scramble);
    build_model();
    start_run();
    if (scramble) scramble_inputs();
    wait_done(edges);
    check({tag, "_latency"}, 0, 32'(edges), 32'(MACS));
    check_results(tag);
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    fh   = '0;
    fx   = '0;
    repeat (3) @(negedge clk);
    check("reset_done", 0, 32'(done), 32'd0);
    check("reset_result_nonzero", 0, 32'(res !== '0), 32'd0);
    rst = 1'b0;

    // Impulse response
    fill_const(0, 0);
    x_m[0] = 16384;
    for (int j = 0; j < FL; j++) h_m[j] = j * 16;
    run_once("impulse", 1'b0);
    check("impulse_y5", 5, 32'(y_at(5)), 32'd40);
    check("impulse_y19", 19, 32'(y_at(19)), 32'd152);
    check("impulse_y20", 20, 32'(y_at(20)), 32'd0);

    // Boxcar: each term contributes 0x0020
    fill_const(16'h0400, 16'h0400);
    run_once("boxcar", 1'b0);
    check("boxcar_y0", 0, 32'(y_at(0)), 32'h0020);
    check("boxcar_y19", 19, 32'(y_at(19)), 32'h0280);
    check("boxcar_y120", 120, 32'(y_at(120)), 32'h0280);
    check("boxcar_y139", 139, 32'(y_at(139)), 32'h0020);

    // Saturation cases
    fill_const(32767, 32767);
    run_once("sat_max", 1'b1);
    check("sat_max_y19", 19, 32'(y_at(19)), 32'h7FFF);
    check("sat_max_y120", 120, 32'(y_at(120)), 32'h7FFF);

    fill_const(0, 0);
    h_m[0] = -32768;
    x_m[0] = -32768;
    run_once("sat_neg_neg", 1'b0);
    check("sat_neg_neg_y0", 0, 32'(y_at(0)), 32'h7FFF);

    h_m[0] = 32767;
    run_once("sat_pos_neg", 1'b0);
    check("sat_pos_neg_y0", 0, 32'(y_at(0)), 32'h8001);

    // Random data, inputs disturbed after load falls
    fill_random(32768);
    run_once("rand_full", 1'b1);
    fill_random(4096);
    run_once("rand_small", 1'b1);

    // Asynchronous reset mid-run
    fill_random(8192);
    build_model();
    start_run();
    repeat (1000) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_done", 0, 32'(done), 32'd0);
    check("midrst_result_nonzero", 0, 32'(res !== '0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fill_random(16384);
    run_once("after_rst", 1'b0);

    // Reload mid-run with new vectors
    fill_random(32768);
    build_model();
    start_run();
    repeat (500) @(posedge clk);
    fill_random(2048);
    run_once("reload", 1'b1);

    // Hold in DONE while inputs change
    scramble_inputs();
    repeat (50) @(negedge clk);
    check("hold_done", 0, 32'(done), 32'd1);
    check_results("hold");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
